p_run_controller: RTL and testbench

Synthesizable run controller for the pipelined processor. Sequences core reset release and the `load_pc` boot pulse, then runs the core for a programmable cycle budget or until halted. While running, it compresses up to NCH observed result channels (e.g. `zed`, `alu_result`) into a MISR signature. It replaces the fixed reset/load_pc/wait stimulus with a reusable block usable both on-chip and in benches.

---
 rtl/p_run_controller_pkg.sv | 17 +
 rtl/p_run_controller_if.sv | 32 +++
 rtl/p_run_controller_misr.sv | 29 ++
 rtl/p_run_controller.sv | 134 +++++++++++++
 tb/tb_p_run_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/p_run_controller_pkg.sv
// Shared types and defaults for the processor run controller.
// The state enum, MISR defaults and counter width live here so the bench and RTL agree.
package p_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } run_state_t;

    localparam logic [31:0] P_POLY_DEFAULT = 32'h04C11DB7;
    localparam logic [31:0] P_SEED_DEFAULT = 32'h0000_0000;
    localparam int          CNT_W          = 32;

endpackage

// File: rtl/p_run_controller_if.sv
// Control, status and observation bundle between a run controller and whatever drives it.
// The master modport is the requester and observation source; the slave modport is the controller.
interface p_run_controller_if
    import p_run_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 2
);
    logic                  start;
    logic [CNT_W-1:0]      run_cycles;
    logic                  halt_req;
    logic [NCH*DATA_W-1:0] obs_data;
    logic [NCH-1:0]        obs_valid;
    logic                  core_reset;
    logic                  load_pc;
    logic                  busy;
    logic                  done;
    logic                  halted;
    logic [DATA_W-1:0]     signature;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output start, run_cycles, halt_req, obs_data, obs_valid,
        input  core_reset, load_pc, busy, done, halted, signature, cycle_count
    );

    modport slave (
        input  start, run_cycles, halt_req, obs_data, obs_valid,
        output core_reset, load_pc, busy, done, halted, signature, cycle_count
    );

endinterface

// File: rtl/p_run_controller_misr.sv
// Combinational next-signature for a multi-channel MISR; zero latency, no flow control.
// Valid channels are folded in ascending order, each fold chained onto the previous one.
module p_misr #(
    parameter int                DATA_W = 32,
    parameter int                NCH    = 2,
    parameter logic [DATA_W-1:0] POLY   = '0
) (
    input  logic [DATA_W-1:0]     i_sig,
    input  logic [NCH*DATA_W-1:0] i_obs_data,
    input  logic [NCH-1:0]        i_obs_valid,
    output logic [DATA_W-1:0]     o_sig_nxt
);

    logic [DATA_W-1:0] w_sig;

    always_comb begin
        w_sig = i_sig;
        for (int c = 0; c < NCH; c++) begin
            if (i_obs_valid[c]) begin
                w_sig = {w_sig[DATA_W-2:0], 1'b0}
                      ^ (w_sig[DATA_W-1] ? POLY : '0)
                      ^ i_obs_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign o_sig_nxt = w_sig;

endmodule

// File: rtl/p_run_controller.sv
// Run controller: reset -> load_pc boot pulse -> budgeted/halted RUN with MISR compression -> DONE.
// Outputs are registered state decodes; start is only honoured in IDLE or DONE, never back-pressured.
module p_run_controller
    import p_run_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          NCH         = 2,
    parameter int          RST_CYCLES  = 2,
    parameter int          BOOT_CYCLES = 1,
    parameter logic [31:0] POLY        = P_POLY_DEFAULT,
    parameter logic [31:0] SEED        = P_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    p_run_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0]  L_RST_LD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  L_BOOT_LD = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [DATA_W-1:0] L_SEED    = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] L_POLY    = DATA_W'(POLY);

    run_state_t        r_state;
    run_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_phase_cnt;
    logic [CNT_W-1:0]  r_budget;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [DATA_W-1:0] r_sig;
    logic [DATA_W-1:0] w_sig_nxt;
    logic              r_halted;
    logic              w_start_ok;
    logic              w_budget_end;
    logic              w_core_reset;
    logic              w_load_pc;
    logic              w_busy;
    logic              w_done;

    p_misr #(
        .DATA_W (DATA_W),
        .NCH    (NCH),
        .POLY   (L_POLY)
    ) u_misr (
        .i_sig       (r_sig),
        .i_obs_data  (bus.obs_data),
        .i_obs_valid (bus.obs_valid),
        .o_sig_nxt   (w_sig_nxt)
    );

    assign w_start_ok   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_inc    = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
    // A zero budget means run until halted; otherwise stop on the cycle that reaches it.
    assign w_budget_end = (r_budget != '0) && (w_cnt_inc >= r_budget);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_core_reset = 1'b0;
        w_load_pc    = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_core_reset = 1'b1;
                if (bus.start) w_state_nxt = ST_RESET;
            end
            ST_RESET: begin
                w_core_reset = 1'b1;
                w_busy       = 1'b1;
                if (r_phase_cnt == '0) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_load_pc = 1'b1;
                w_busy    = 1'b1;
                if (r_phase_cnt == '0) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (bus.halt_req || w_budget_end) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) w_state_nxt = ST_RESET;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase_cnt <= '0;
            r_budget    <= '0;
            r_cycle_cnt <= '0;
            r_sig       <= L_SEED;
            r_halted    <= 1'b0;
        end else if (w_start_ok) begin
            r_phase_cnt <= L_RST_LD;
            r_budget    <= bus.run_cycles;
            r_cycle_cnt <= '0;
            r_sig       <= L_SEED;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                // One down-counter times both phases; RESET reloads it for LOAD on expiry.
                ST_RESET: r_phase_cnt <= (r_phase_cnt == '0) ? L_BOOT_LD : r_phase_cnt - 1'b1;
                ST_LOAD: begin
                    if (r_phase_cnt != '0) r_phase_cnt <= r_phase_cnt - 1'b1;
                end
                ST_RUN: begin
                    r_cycle_cnt <= w_cnt_inc;
                    r_sig       <= w_sig_nxt;
                    r_halted    <= bus.halt_req;
                end
                default: ;
            endcase
        end
    end

    assign bus.core_reset  = w_core_reset;
    assign bus.load_pc     = w_load_pc;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.halted      = r_halted;
    assign bus.signature   = r_sig;
    assign bus.cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_p_run_controller.sv
// Randomized scoreboard bench for p_run_controller (DATA_W=8, NCH=2, POLY=0x1D, SEED=0).
module tb_p_run_controller;

    localparam int MAXR = 64;

    typedef struct {
        logic [7:0]  sig;
        logic [31:0] cnt;
        logic        halted;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    logic prev_done;

    logic [7:0] sd0 [MAXR];
    logic [7:0] sd1 [MAXR];
    logic [1:0] sv  [MAXR];

    p_run_controller_if #(.DATA_W(8), .NCH(2)) bus ();

    p_run_controller #(
        .DATA_W      (8),
        .NCH         (2),
        .RST_CYCLES  (2),
        .BOOT_CYCLES (1),
        .POLY        (32'h0000_001D),
        .SEED        (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature as polynomial division over GF(2): multiply by x, reduce mod x^8+POLY, add data.
    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] d);
        int v;
        v = int'(s) * 2;
        if (v > 255) v = (v - 256) ^ 'h1D;
        return 8'(v) ^ d;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done && !prev_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_signature", {24'd0, bus.signature}, {24'd0, e.sig});
                chk("sb_cycle_count", bus.cycle_count, e.cnt);
                chk("sb_halted", {31'd0, bus.halted}, {31'd0, e.halted});
            end
        end
        prev_done = bus.done;
    end

    task automatic drive_random_obs();
        bus.obs_data  = 16'($urandom);
        bus.obs_valid = 2'($urandom);
    endtask

    // mode 0: random; 1: ch0 0x01 then zeros; 2: ch0 0x80 then zeros; 3: {0x02,0x01} both valid
    task automatic do_run(input logic [31:0] budget, input int halt_at, input int mode,
                          input bit start_mid);
        longint n_run;
        exp_t   e;
        logic [7:0] s;
        if (budget == 0) n_run = halt_at;
        else if (halt_at != 0 && longint'(halt_at) < longint'(budget)) n_run = halt_at;
        else n_run = budget;
        e.halted = (halt_at != 0) && (budget == 0 || longint'(halt_at) <= longint'(budget));
        e.cnt    = 32'(n_run);
        s = 8'h00;
        for (int i = 1; i <= n_run; i++) begin
            sd0[i] = 8'($urandom);
            sd1[i] = 8'($urandom);
            sv[i]  = 2'($urandom);
            if (mode == 1) begin sd0[i] = (i == 1) ? 8'h01 : 8'h00; sv[i] = 2'b01; end
            if (mode == 2) begin sd0[i] = (i == 1) ? 8'h80 : 8'h00; sv[i] = 2'b01; end
            if (mode == 3) begin sd0[i] = 8'h01; sd1[i] = 8'h02; sv[i] = 2'b11; end
            if (sv[i][0]) s = misr_ref(s, sd0[i]);
            if (sv[i][1]) s = misr_ref(s, sd1[i]);
        end
        e.sig = s;

        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.run_cycles = budget;
        drive_random_obs();
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.run_cycles = $urandom;
        drive_random_obs();
        chk("reset_core_reset", {31'd0, bus.core_reset}, 32'd1);
        chk("reset_load_pc", {31'd0, bus.load_pc}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd1);
        chk("start_clears_sig", {24'd0, bus.signature}, 32'd0);
        chk("start_clears_cnt", bus.cycle_count, 32'd0);
        chk("start_clears_halted", {31'd0, bus.halted}, 32'd0);
        @(posedge clk); #1;
        bus.start = start_mid;
        drive_random_obs();
        chk("reset2_core_reset", {31'd0, bus.core_reset}, 32'd1);
        chk("reset2_load_pc", {31'd0, bus.load_pc}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive_random_obs();
        chk("load_core_reset", {31'd0, bus.core_reset}, 32'd0);
        chk("load_load_pc", {31'd0, bus.load_pc}, 32'd1);
        for (int i = 1; i <= n_run; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk("run_load_pc", {31'd0, bus.load_pc}, 32'd0);
                chk("run_core_reset", {31'd0, bus.core_reset}, 32'd0);
                chk("run_busy", {31'd0, bus.busy}, 32'd1);
            end
            bus.obs_data  = {sd1[i], sd0[i]};
            bus.obs_valid = sv[i];
            bus.halt_req  = (i == halt_at);
            bus.start     = start_mid && (i == 3);
        end
        @(posedge clk); #1;
        bus.halt_req = 1'b0;
        bus.start    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_random_obs();
            bus.halt_req = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.halt_req  = 1'b0;
        bus.obs_valid = 2'b00;
        chk("done_sig_stable", {24'd0, bus.signature}, {24'd0, e.sig});
        chk("done_cnt_stable", bus.cycle_count, e.cnt);
        chk("done_flag", {31'd0, bus.done}, 32'd1);
        chk("done_busy", {31'd0, bus.busy}, 32'd0);
        chk("done_core_reset", {31'd0, bus.core_reset}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        prev_done = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.run_cycles = '0;
        bus.halt_req = 1'b0;
        bus.obs_data = '0;
        bus.obs_valid = '0;
        #22;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_random_obs();
            bus.halt_req = 1'($urandom);
            @(posedge clk); #1;
            chk("idle_core_reset", {31'd0, bus.core_reset}, 32'd1);
            chk("idle_load_pc", {31'd0, bus.load_pc}, 32'd0);
            chk("idle_busy", {31'd0, bus.busy}, 32'd0);
            chk("idle_signature", {24'd0, bus.signature}, 32'd0);
        end
        bus.halt_req = 1'b0;

        do_run(32'd5, 0, 0, 1'b0);
        do_run(32'd9, 0, 1, 1'b0);
        chk("vec_01_then_zeros", {24'd0, bus.signature}, 32'h1D);
        do_run(32'd2, 0, 2, 1'b0);
        chk("vec_80_then_zero", {24'd0, bus.signature}, 32'h1D);
        do_run(32'd1, 0, 3, 1'b0);
        chk("vec_two_channels", {24'd0, bus.signature}, 32'h00);
        do_run(32'd0, 37, 0, 1'b0);
        do_run(32'd10, 0, 0, 1'b1);
        do_run(32'd6, 6, 0, 1'b0);
        do_run(32'hFFFF_FFFF, 4, 0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            do_run(32'($urandom_range(1, 20)),
                   ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25)),
                   0, 1'($urandom));
        end

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.run_cycles = 32'd50;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive_random_obs();
        bus.obs_valid = 2'b11;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_core_reset", {31'd0, bus.core_reset}, 32'd1);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_signature", {24'd0, bus.signature}, 32'd0);
        chk("abort_cycle_count", bus.cycle_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.obs_valid = 2'b00;
        do_run(32'd3, 0, 0, 1'b0);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
